// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register file write port
//
// Shares the single register-file write port between NREQ writeback sources.
// One source is granted per cycle in rotating priority order. The winning write
// is registered into an output stage that drives the register file the next cycle.
//
// Ports:
//   i_clk         clock, all state on rising edge
//   i_rst_n       synchronous active-low reset
//   i_hold        suppress any grant this cycle
//   i_valid       per-requester write request
//   i_addr        requester k destination register in [5k+4:5k]
//   i_data        requester k write data in [XLEN*k+XLEN-1:XLEN*k]
//   o_ready       one-hot-or-zero grant
//   o_write       register-file write enable
//   o_waddr       register-file write address
//   o_wdata       register-file write data
//   o_pending     bit r set while the output stage holds a write to register r
//   o_last_grant  one-hot index of the most recent grant
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_hold,
   input  logic [NREQ-1:0]      i_valid,
   input  logic [NREQ*5-1:0]    i_addr,
   input  logic [NREQ*XLEN-1:0] i_data,
   output logic [NREQ-1:0]      o_ready,
   output logic                 o_write,
   output logic [4:0]           o_waddr,
   output logic [XLEN-1:0]      o_wdata,
   output logic [31:0]          o_pending,
   output logic [NREQ-1:0]      o_last_grant
);

   localparam int            PW       = $clog2(NREQ);
   localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);
   localparam logic [PW-1:0] PTR_LAST = PW'(NREQ-1);

   logic [PW-1:0]   ptr;
   logic [4:0]      addr_arr [NREQ];
   logic [XLEN-1:0] data_arr [NREQ];

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   gnt_idx;
   logic            gnt_any;
   logic [PW:0]     scan;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_arr[g] = i_addr[5*g +: 5];
      assign data_arr[g] = i_data[XLEN*g +: XLEN];
   end

   // Scan from ptr upward, wrapping; the first valid requester wins. The scan
   // index is one bit wider than ptr so ptr+j never overflows before the wrap.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      scan    = '0;
      if (i_rst_n && !i_hold) begin
         for (int j = 0; j < NREQ; j++) begin
            scan = {1'b0, ptr} + j[PW:0];
            if (scan >= NREQ_W) begin
               scan = scan - NREQ_W;
            end
            if (!gnt_any && i_valid[scan[PW-1:0]]) begin
               grant[scan[PW-1:0]] = 1'b1;
               gnt_idx             = scan[PW-1:0];
               gnt_any             = 1'b1;
            end
         end
      end
   end

   assign o_ready = grant;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ptr          <= '0;
         o_write      <= 1'b0;
         o_waddr      <= '0;
         o_wdata      <= '0;
         o_last_grant <= '0;
      end else begin
         // A write to x0 is consumed like any other but never enables the port.
         o_write <= gnt_any && (addr_arr[gnt_idx] != 5'd0);
         if (gnt_any) begin
            ptr          <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
            o_waddr      <= addr_arr[gnt_idx];
            o_wdata      <= data_arr[gnt_idx];
            o_last_grant <= grant;
         end
      end
   end

   always_comb begin
      o_pending = '0;
      if (o_write && (o_waddr != 5'd0)) begin
         o_pending[o_waddr] = 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_hold;
   logic [2:0]  i_valid;
   logic [14:0] i_addr;
   logic [95:0] i_data;
   logic [2:0]  o_ready;
   logic        o_write;
   logic [4:0]  o_waddr;
   logic [31:0] o_wdata;
   logic [31:0] o_pending;
   logic [2:0]  o_last_grant;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] rf [32];
   int          n_tests = 0;
   int          n_fail  = 0;

   regfile_wb_arbiter #(.NREQ(3), .XLEN(32)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_hold       (i_hold),
      .i_valid      (i_valid),
      .i_addr       (i_addr),
      .i_data       (i_data),
      .o_ready      (o_ready),
      .o_write      (o_write),
      .o_waddr      (o_waddr),
      .o_wdata      (o_wdata),
      .o_pending    (o_pending),
      .o_last_grant (o_last_grant)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Register file model: it ignores the port while reset is asserted.
   always @(posedge i_clk) begin
      if (i_rst_n === 1'b1 && o_write === 1'b1 && o_waddr != 5'd0) begin
         rf[o_waddr] <= o_wdata;
      end
   end

   // Monitor: every committed write must match the head of the scoreboard.
   always @(negedge i_clk) begin
      if (i_rst_n === 1'b1) begin
         if (o_write === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %0d data %h expected no write", o_waddr, o_wdata);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("waddr", {27'd0, o_waddr}, {27'd0, e.a});
               chk("wdata", o_wdata, e.d);
               chk("pending_busy", o_pending, 32'd1 << e.a);
            end
         end else begin
            chk("pending_idle", o_pending, 32'd0);
         end
      end
   end

   function automatic logic [14:0] pa(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
      return {a2, a1, a0};
   endfunction

   function automatic logic [95:0] pd(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
      return {d2, d1, d0};
   endfunction

   // One cycle: drive inputs, check grant mid-cycle, queue the expected write,
   // then check o_last_grant just after the edge.
   task automatic step(input logic rst_n, input logic hold, input logic [2:0] v,
                       input logic [14:0] a, input logic [95:0] d,
                       input logic [2:0] exp_rdy, input bit push, input logic [2:0] exp_lg);
      i_rst_n = rst_n;
      i_hold  = hold;
      i_valid = v;
      i_addr  = a;
      i_data  = d;
      @(negedge i_clk);
      chk("ready", {29'd0, o_ready}, {29'd0, exp_rdy});
      if (push) begin
         for (int k = 0; k < 3; k++) begin
            if (exp_rdy[k] && a[5*k +: 5] != 5'd0) begin
               exp_q.push_back({a[5*k +: 5], d[32*k +: 32]});
            end
         end
      end
      @(posedge i_clk);
      #1;
      chk("last_grant", {29'd0, o_last_grant}, {29'd0, exp_lg});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [14:0] fa;
      logic [95:0] fd;
      logic [2:0]  fexp;
      for (int r = 0; r < 32; r++) rf[r] = 32'd0;
      i_rst_n = 1'b0;
      i_hold  = 1'b0;
      i_valid = '0;
      i_addr  = '0;
      i_data  = '0;
      @(posedge i_clk);
      #1;

      // Reset with every requester valid: no grant, output stage cleared.
      step(0, 0, 3'b111, pa(1, 2, 3), pd(1, 2, 3), 3'b000, 0, 3'b000);
      step(0, 0, 3'b111, pa(1, 2, 3), pd(1, 2, 3), 3'b000, 0, 3'b000);
      chk("rst_write", {31'd0, o_write}, 32'd0);
      chk("rst_waddr", {27'd0, o_waddr}, 32'd0);
      chk("rst_wdata", o_wdata, 32'd0);
      chk("rst_pending", o_pending, 32'd0);

      // Single requester 1 -> x5.
      step(1, 0, 3'b000, '0, '0, 3'b000, 0, 3'b000);
      step(1, 0, 3'b010, pa(0, 5, 0), pd(0, 32'hDEADBEEF, 0), 3'b010, 1, 3'b010);
      chk("single_write", {31'd0, o_write}, 32'd1);
      chk("single_pending", o_pending, 32'h0000_0020);
      step(1, 0, 3'b000, '0, '0, 3'b000, 0, 3'b010);
      chk("rf5", rf[5], 32'hDEADBEEF);

      // Fairness from a fresh reset: 0,1,2,0,1,2.
      step(0, 0, 3'b000, '0, '0, 3'b000, 0, 3'b000);
      fa = pa(1, 2, 3);
      fd = pd(32'h100, 32'h200, 32'h300);
      for (int c = 0; c < 6; c++) begin
         fexp = 3'b001 << (c % 3);
         step(1, 0, 3'b111, fa, fd, fexp, 1, fexp);
      end

      // x0 discard: move ptr to 1, grant requester 2 to x0, ptr must wrap to 0.
      step(1, 0, 3'b001, pa(4, 0, 0), pd(32'h44, 0, 0), 3'b001, 1, 3'b001);
      step(1, 0, 3'b100, pa(0, 0, 0), pd(0, 0, 32'h12345678), 3'b100, 1, 3'b100);
      chk("x0_write", {31'd0, o_write}, 32'd0);
      chk("x0_pending", o_pending, 32'd0);
      step(1, 0, 3'b011, pa(12, 13, 0), pd(32'hC0, 32'hD0, 0), 3'b001, 1, 3'b001);
      step(1, 0, 3'b010, pa(0, 13, 0), pd(0, 32'hD0, 0), 3'b010, 1, 3'b010);

      // Hold with ptr=2, then release: 2 first, then wrap to 0.
      step(1, 1, 3'b101, pa(9, 0, 11), pd(32'h900, 0, 32'hB00), 3'b000, 1, 3'b010);
      chk("hold_write", {31'd0, o_write}, 32'd0);
      step(1, 0, 3'b101, pa(9, 0, 11), pd(32'h900, 0, 32'hB00), 3'b100, 1, 3'b100);
      step(1, 0, 3'b001, pa(9, 0, 0), pd(32'h900, 0, 0), 3'b001, 1, 3'b001);

      // Reset right after a grant to x7: the held write is discarded.
      step(1, 0, 3'b001, pa(7, 0, 0), pd(32'hA5A5A5A5, 0, 0), 3'b001, 0, 3'b001);
      step(0, 0, 3'b000, '0, '0, 3'b000, 0, 3'b000);
      chk("midrst_write", {31'd0, o_write}, 32'd0);
      step(1, 0, 3'b000, '0, '0, 3'b000, 0, 3'b000);
      step(1, 0, 3'b000, '0, '0, 3'b000, 0, 3'b000);

      chk("rf7", rf[7], 32'd0);
      chk("rf0", rf[0], 32'd0);
      chk("rf3", rf[3], 32'h300);
      chk("rf9", rf[9], 32'h900);
      chk("rf11", rf[11], 32'hB00);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Round-robin writeback arbiter that shares the register file's single write port between NREQ writeback sources (ALU, load unit, CSR unit). Each source offers a write with a valid/ready handshake. The arbiter grants one source per cycle and registers the winning write into an output stage that drives the register file's write-enable, address and data the following cycle. It also reports which architectural register has a write in flight, so hazard logic can stall or forward.

## Interface
Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_hold  in  1  when high, no grant is issued this cycle
- i_valid  in  NREQ  per-requester write request
- i_addr  in  NREQ*5  requester k's destination register in bits [5k+4:5k]
- i_data  in  NREQ*XLEN  requester k's write data in bits [XLEN*k+XLEN-1:XLEN*k]
- o_ready  out  NREQ  one-hot-or-zero grant; handshake completes when i_valid[k] and o_ready[k] are both high
- o_write  out  1  register-file write enable
- o_waddr  out  5  register-file write address
- o_wdata  out  XLEN  register-file write data
- o_pending  out  32  bit r is high while the output stage holds a write to register r (r != 0)
- o_last_grant  out  NREQ  one-hot index of the most recent grant; zero after reset

## Operation
- State:
  - rotating priority pointer ptr, range 0..NREQ-1
  - output stage: o_write, o_waddr, o_wdata, o_last_grant
- Grant selection (combinational, same cycle):
  - If i_hold is high or i_valid is zero: o_ready = 0.
  - Otherwise scan indices ptr, ptr+1, …, wrapping modulo NREQ. The first k with i_valid[k]=1 gets o_ready[k]=1.
  - At most one o_ready bit is high. o_ready[k] never goes high while i_valid[k] is low.
- On a completed handshake for requester k at edge N:
  - ptr <= (k+1) mod NREQ; wrap from NREQ-1 goes to 0.
  - o_waddr <= i_addr[k] and o_wdata <= i_data[k].
  - o_last_grant <= one-hot(k).
  - o_write <= 1 if i_addr[k] != 0, else 0. A write to x0 is accepted and consumed but never reaches the register file.
- With no handshake at an edge:
  - o_write <= 0.
  - o_waddr, o_wdata, o_last_grant and ptr hold their values.
- o_pending is combinational from the output stage:
  - o_pending[o_waddr] = o_write; all other bits are 0.
  - o_pending[0] is always 0.
- Requester obligations:
  - Hold i_valid, address and data stable until the handshake completes.
  - Do not withdraw i_valid without a grant.
  - The arbiter does not check these; violations give undefined results.
- The register file accepts every write, so the output stage never back-pressures. The arbiter sustains one write per cycle.
- Same-register writes from different requesters are not merged or reordered. They commit in grant order, and the later grant wins.

## Timing
- Reset: when i_rst_n is low at an edge:
  - o_write=0, o_waddr=0, o_wdata=0, o_last_grant=0, ptr=0.
  - o_ready is forced to 0 while i_rst_n is low.
  - A handshake presented during reset is not accepted.
- Reset mid-operation discards any write held in the output stage. It is not committed.
- Latency: handshake at edge N drives o_write from cycle N+1. The register file captures the write at edge N+1.
- o_ready depends combinationally on i_valid, i_hold, i_rst_n and ptr. There is no combinational path from o_* outputs back to o_ready.
- Throughput: one grant per cycle. With all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.
- i_hold asserted at the same edge as a pending request: no grant, o_write drops to 0 the next cycle, ptr unchanged.
- Starvation bound: a continuously valid requester is granted within NREQ cycles when i_hold is low.

## Test plan
- Reset: hold i_rst_n=0 for 2 cycles with i_valid=3'b111 -> o_ready=0 throughout; o_write=0, o_waddr=0, o_wdata=0, o_pending=0.
- Single requester: i_valid=3'b010, i_addr[1]=5, i_data[1]=0xDEADBEEF -> o_ready=3'b010 that cycle. Next cycle o_write=1, o_waddr=5, o_wdata=0xDEADBEEF, o_pending=0x00000020. Register 5 reads 0xDEADBEEF after that edge.
- Fairness: all three continuously valid for 6 cycles after reset -> grant order 0,1,2,0,1,2. o_last_grant follows 001,010,100,… one cycle later.
- x0 discard: requester 2 writes addr 0, data 0x12345678 -> handshake completes and ptr advances to 0. Next cycle o_write=0, o_pending=0, register 0 still reads 0.
- Hold and wrap: ptr=2, i_valid=3'b101, i_hold=1 for one cycle -> no grant, o_write=0 next cycle. Release hold -> requester 2 granted first, then requester 0 (ptr wraps 2->0->1).
- Reset mid-write: grant requester 0 (addr 7, data 0xA5A5A5A5), then assert i_rst_n=0 at the next edge -> o_write=0 after that edge and register 7 unchanged.
